// File: rtl/fir_mac_sched_if.sv
// Purpose: handshake/memory bundle between the FIR MAC sequencer and its environment.
// Ports: start/wr_ptr/filt_sel/dc_en request, sample + coefficient BRAM read ports,
//        busy/done/result/drop status. master = sequencer side, slave = environment side.
interface fir_mac_sched_if #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int COEF_W      = 32,
  parameter int COEF_ADDR_W = 7
);
  logic                   start;
  logic [ADDR_W-1:0]      wr_ptr;
  logic [1:0]             filt_sel;
  logic                   dc_en;
  logic [ADDR_W-1:0]      xant_addr;
  logic                   xant_rd;
  logic [DATA_W-1:0]      xant_q;
  logic [COEF_ADDR_W-1:0] coef_addr;
  logic                   coef_rd;
  logic [COEF_W-1:0]      coef_q;
  logic                   busy;
  logic                   done;
  logic [DATA_W-1:0]      result;
  logic                   drop;

  modport master (
    input  start, wr_ptr, filt_sel, dc_en, xant_q, coef_q,
    output xant_addr, xant_rd, coef_addr, coef_rd, busy, done, result, drop
  );

  modport slave (
    output start, wr_ptr, filt_sel, dc_en, xant_q, coef_q,
    input  xant_addr, xant_rd, coef_addr, coef_rd, busy, done, result, drop
  );
endinterface

// File: rtl/fir_mac_sched.sv
// Purpose: sequences one shared FIR MAC over M taps (ring buffer newest->oldest, coef bank =
//          filter select), rounds half up and saturates to DATA_W; bypass returns x[n] as is.
// Ports: clk, rst (async, active-high), bus (fir_mac_sched_if.master). Latency: done at E0+M+2
//        (bypass E0+2); busy from accept through done; a start while busy is dropped with a pulse.
module fir_mac_sched #(
  parameter int M           = 23,
  parameter int DATA_W      = 16,
  parameter int COEF_W      = 32,
  parameter int FRAC_BITS   = 30,
  parameter int ADDR_W      = 5,
  parameter int COEF_ADDR_W = 7,
  parameter int ACC_W       = 56
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_mac_sched_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAST, S_ROUND, S_DONE, S_BYP_RD, S_BYP_WAIT
  } state_e;

  localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(M - 1);
  localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2 ** (DATA_W - 1)));

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic [1:0]               fsel_q, fsel_d;
  logic                     dc_q, dc_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     mac_vld_q;
  logic [ADDR_W-1:0]        xant_addr_q, xant_addr_d;
  logic                     xant_rd_q, xant_rd_d;
  logic [COEF_ADDR_W-1:0]   coef_addr_q, coef_addr_d;
  logic                     coef_rd_q, coef_rd_d;
  logic [DATA_W-1:0]        result_q, result_d;

  logic [ADDR_W-1:0]        wr_clamp;
  logic signed [DATA_W:0]   sx;
  logic signed [ACC_W-1:0]  coef_ext, sx_ext, prod;
  logic signed [ACC_W-1:0]  rsum, rshift;
  logic [DATA_W-1:0]        sat, rnd_res;

  // Out-of-range ring pointers are pinned to the last slot so no address beyond M-1 is issued.
  assign wr_clamp = (bus.wr_ptr > LAST_IDX) ? LAST_IDX : bus.wr_ptr;

  always_comb begin
    // Offset-binary minus half scale is just the MSB flipped, then sign-extended.
    sx = dc_q ? {~bus.xant_q[DATA_W-1], ~bus.xant_q[DATA_W-1], bus.xant_q[DATA_W-2:0]}
              : {bus.xant_q[DATA_W-1], bus.xant_q};
    coef_ext = ACC_W'($signed(bus.coef_q));
    sx_ext   = ACC_W'(sx);
    prod     = coef_ext * sx_ext;

    rsum   = acc_q + HALF;
    rshift = rsum >>> FRAC_BITS;
    if (rshift > SAT_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (rshift < SAT_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                       sat = rshift[DATA_W-1:0];
    rnd_res = dc_q ? {~sat[DATA_W-1], sat[DATA_W-2:0]} : sat;
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    fsel_d      = fsel_q;
    dc_d        = dc_q;
    acc_d       = acc_q;
    xant_addr_d = xant_addr_q;
    xant_rd_d   = 1'b0;
    coef_addr_d = coef_addr_q;
    coef_rd_d   = 1'b0;
    result_d    = result_q;

    // BRAM data for the tap issued last cycle is present now.
    if (mac_vld_q) acc_d = acc_q + prod;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          fsel_d      = bus.filt_sel;
          dc_d        = bus.dc_en;
          acc_d       = '0;
          k_d         = '0;
          xant_addr_d = wr_clamp;
          xant_rd_d   = 1'b1;
          if (bus.filt_sel == 2'b11) begin
            state_d = S_BYP_RD;
          end else begin
            coef_rd_d   = 1'b1;
            coef_addr_d = {bus.filt_sel, {ADDR_W{1'b0}}};
            state_d     = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (k_q == LAST_IDX) begin
          state_d = S_LAST;
        end else begin
          k_d         = k_q + ADDR_W'(1);
          xant_rd_d   = 1'b1;
          coef_rd_d   = 1'b1;
          // Step one sample older, wrapping 0 -> M-1.
          xant_addr_d = (xant_addr_q == '0) ? LAST_IDX : xant_addr_q - ADDR_W'(1);
          coef_addr_d = {fsel_q, k_q + ADDR_W'(1)};
        end
      end
      S_LAST:     state_d = S_ROUND;
      S_ROUND: begin
        result_d = rnd_res;
        state_d  = S_DONE;
      end
      S_DONE:     state_d = S_IDLE;
      S_BYP_RD:   state_d = S_BYP_WAIT;
      S_BYP_WAIT: begin
        result_d = bus.xant_q;
        state_d  = S_DONE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      fsel_q      <= '0;
      dc_q        <= 1'b0;
      acc_q       <= '0;
      mac_vld_q   <= 1'b0;
      xant_addr_q <= '0;
      xant_rd_q   <= 1'b0;
      coef_addr_q <= '0;
      coef_rd_q   <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      fsel_q      <= fsel_d;
      dc_q        <= dc_d;
      acc_q       <= acc_d;
      mac_vld_q   <= (state_q == S_FETCH);
      xant_addr_q <= xant_addr_d;
      xant_rd_q   <= xant_rd_d;
      coef_addr_q <= coef_addr_d;
      coef_rd_q   <= coef_rd_d;
      result_q    <= result_d;
    end
  end

  assign bus.xant_addr = xant_addr_q;
  assign bus.xant_rd   = xant_rd_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.coef_rd   = coef_rd_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.drop      = bus.start && (state_q != S_IDLE);

endmodule
